// File: rtl/conv_pkg.sv
// Shared constants, memory-select codes and FSM states for the pooling/flatten engine.
package conv_pkg;

  localparam int unsigned DW    = 20;
  localparam int unsigned AW    = 12;
  localparam int unsigned MAP_W = 64;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WR_L1,
    WR_L2,
    DONE
  } state_e;

endpackage

// File: rtl/pool_flatten_if.sv
// Shared conv-stage memory port: one read channel, one write channel, common select.
interface pool_flatten_if #(
  parameter int unsigned DW = 20,
  parameter int unsigned AW = 12
);

  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  modport master (
    output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    input  cdata_rd
  );

  modport slave (
    input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    output cdata_rd
  );

endinterface

// File: rtl/pool_addr_gen.sv
// Pooled-pixel row/column/kernel counters and the L0 read, L1 and L2 write addresses.
module pool_addr_gen #(
  parameter int unsigned AW    = 12,
  parameter int unsigned MAP_W = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  input  logic [1:0]    rsel,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] l1_addr,
  output logic [AW-1:0] l2_addr,
  output logic          kern,
  output logic          last_pix
);
  import conv_pkg::*;

  localparam int unsigned PW = MAP_W / 2;
  localparam int unsigned CW = $clog2(PW);

  logic [CW-1:0] r_q, c_q;
  logic          k_q;
  logic [AW-1:0] a0, offset;

  // Wrapping past the last pixel of kernel 1 leaves every counter at zero for the next run.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_q <= '0;
      c_q <= '0;
      k_q <= 1'b0;
    end else if (step) begin
      if (c_q == CW'(PW - 1)) begin
        c_q <= '0;
        if (r_q == CW'(PW - 1)) begin
          r_q <= '0;
          k_q <= ~k_q;
        end else begin
          r_q <= r_q + 1'b1;
        end
      end else begin
        c_q <= c_q + 1'b1;
      end
    end
  end

  always_comb begin
    offset = '0;
    unique case (rsel)
      2'd0: offset = '0;
      2'd1: offset = AW'(1);
      2'd2: offset = AW'(MAP_W);
      2'd3: offset = AW'(MAP_W + 1);
      default: offset = '0;
    endcase
  end

  assign a0       = AW'(r_q) * AW'(2 * MAP_W) + AW'({c_q, 1'b0});
  assign rd_addr  = a0 + offset;
  assign l1_addr  = AW'({r_q, c_q});
  assign l2_addr  = AW'({r_q, c_q, k_q});
  assign kern     = k_q;
  assign last_pix = (r_q == CW'(PW - 1)) && (c_q == CW'(PW - 1));

endmodule

// File: rtl/pool_flatten.sv
// 2x2/stride-2 max-pool of both L0 maps into L1, interleaved flatten into L2.
// Define POOL_RELU_EN to clamp negative pooled values to zero before writing.
module pool_flatten #(
  parameter int unsigned DW    = conv_pkg::DW,
  parameter int unsigned AW    = conv_pkg::AW,
  parameter int unsigned MAP_W = conv_pkg::MAP_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  pool_flatten_if.master mem
);
  import conv_pkg::*;

  state_e                state_q;
  logic [1:0]            rcnt_q;
  logic signed [DW-1:0]  acc_q;
  logic                  last_q;

  logic [1:0]            rsel;
  logic                  step, clear;
  logic [AW-1:0]         rd_addr, l1_addr, l2_addr;
  logic                  kern, last_pix;
  logic signed [DW-1:0]  din, pooled_max, pooled;

  pool_addr_gen #(
    .AW    (AW),
    .MAP_W (MAP_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .step     (step),
    .rsel     (rsel),
    .rd_addr  (rd_addr),
    .l1_addr  (l1_addr),
    .l2_addr  (l2_addr),
    .kern     (kern),
    .last_pix (last_pix)
  );

  // rsel looks one read ahead because caddr_rd is registered.
  always_comb begin
    rsel = 2'd0;
    if (state_q == READ) rsel = rcnt_q + 2'd1;
  end

  // Counters advance in WR_L1 so the next pixel's A0 is ready by WR_L2.
  assign step  = (state_q == WR_L1);
  assign clear = (state_q == IDLE);

  assign din        = $signed(mem.cdata_rd);
  assign pooled_max = (din > acc_q) ? din : acc_q;

`ifdef POOL_RELU_EN
  assign pooled = pooled_max[DW-1] ? '0 : pooled_max;
`else
  assign pooled = pooled_max;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rcnt_q       <= '0;
      acc_q        <= '0;
      last_q       <= 1'b0;
      busy         <= 1'b0;
      mem.crd      <= 1'b0;
      mem.caddr_rd <= '0;
      mem.cwr      <= 1'b0;
      mem.caddr_wr <= '0;
      mem.cdata_wr <= '0;
      mem.csel     <= CSEL_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ready) begin
            state_q      <= READ;
            rcnt_q       <= '0;
            busy         <= 1'b1;
            mem.crd      <= 1'b1;
            mem.caddr_rd <= rd_addr;
            mem.csel     <= CSEL_L0K0;
          end
        end
        READ: begin
          rcnt_q <= rcnt_q + 2'd1;
          // First datum loads the accumulator; later ones fold into the max.
          if (rcnt_q == 2'd1)      acc_q <= din;
          else if (rcnt_q != 2'd0) acc_q <= pooled_max;
          if (rcnt_q == 2'd3) begin
            state_q <= DRAIN;
            mem.crd <= 1'b0;
          end else begin
            mem.caddr_rd <= rd_addr;
          end
        end
        DRAIN: begin
          state_q      <= WR_L1;
          mem.cwr      <= 1'b1;
          mem.csel     <= kern ? CSEL_L1K1 : CSEL_L1K0;
          mem.caddr_wr <= l1_addr;
          mem.cdata_wr <= pooled;
        end
        WR_L1: begin
          state_q      <= WR_L2;
          mem.csel     <= CSEL_L2;
          mem.caddr_wr <= l2_addr;
          last_q       <= last_pix && kern;
        end
        WR_L2: begin
          mem.cwr <= 1'b0;
          if (last_q) begin
            state_q  <= DONE;
            busy     <= 1'b0;
            mem.csel <= CSEL_NONE;
          end else begin
            state_q      <= READ;
            rcnt_q       <= '0;
            mem.crd      <= 1'b1;
            mem.caddr_rd <= rd_addr;
            mem.csel     <= kern ? CSEL_L0K1 : CSEL_L0K0;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_flatten.sv
// Directed and model-checked bench for pool_flatten with behavioural L0/L1/L2 memories.
module tb_pool_flatten;

  localparam int DW = 20;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ready = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  pool_flatten_if #(.DW(DW), .AW(AW)) bus ();

  pool_flatten #(.DW(DW), .AW(AW), .MAP_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .ready (ready),
    .busy  (busy),
    .mem   (bus)
  );

  logic [DW-1:0] l0k0 [4096];
  logic [DW-1:0] l0k1 [4096];
  logic [DW-1:0] l1m0 [1024];
  logic [DW-1:0] l1m1 [1024];
  logic [DW-1:0] l2m  [2048];

  logic [AW-1:0] rd_log     [8192];
  logic [2:0]    rd_sel_log [8192];
  int busy_cyc, overlap, rd_idx, wr_cnt;
  logic mon_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  // Memories plus activity monitors.
  always @(posedge clk) begin
    if (bus.crd) begin
      bus.cdata_rd <= (bus.csel == 3'b001) ? l0k0[bus.caddr_rd] :
                      (bus.csel == 3'b010) ? l0k1[bus.caddr_rd] : 'x;
    end
    if (bus.cwr) begin
      case (bus.csel)
        3'b011:  l1m0[bus.caddr_wr[9:0]]  <= bus.cdata_wr;
        3'b100:  l1m1[bus.caddr_wr[9:0]]  <= bus.cdata_wr;
        3'b101:  l2m[bus.caddr_wr[10:0]]  <= bus.cdata_wr;
        default: ;
      endcase
    end
    if (mon_clr) begin
      busy_cyc <= 0;
      overlap  <= 0;
      rd_idx   <= 0;
      wr_cnt   <= 0;
    end else begin
      if (busy) busy_cyc <= busy_cyc + 1;
      if (bus.crd && bus.cwr) overlap <= overlap + 1;
      if (bus.crd) begin
        if (rd_idx < 8192) begin
          rd_log[rd_idx]     <= bus.caddr_rd;
          rd_sel_log[rd_idx] <= bus.csel;
        end
        rd_idx <= rd_idx + 1;
      end
      if (bus.cwr) wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic logic [DW-1:0] ref_pool(int k, int p);
    int r, c, a0, off;
    logic signed [DW-1:0] m, v;
    r  = p / 32;
    c  = p % 32;
    a0 = 2 * r * 64 + 2 * c;
    m  = $signed((k == 1) ? l0k1[a0] : l0k0[a0]);
    for (int j = 1; j < 4; j++) begin
      off = (j == 1) ? 1 : (j == 2) ? 64 : 65;
      v = $signed((k == 1) ? l0k1[a0 + off] : l0k0[a0 + off]);
      if (v > m) m = v;
    end
`ifdef POOL_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%0h exp=0", busy);
    end
    checks++;
    if ({bus.crd, bus.cwr} !== 2'b00) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=00", {bus.crd, bus.cwr});
    end
    checks++;
    if ({bus.caddr_rd, bus.caddr_wr} !== '0) begin
      failures++;
      $display("FAIL reset_addr got=%0h/%0h exp=0/0", bus.caddr_rd, bus.caddr_wr);
    end
    checks++;
    if ({bus.cdata_wr, bus.csel} !== '0) begin
      failures++;
      $display("FAIL reset_data_sel got=%0h/%0h exp=0/0", bus.cdata_wr, bus.csel);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_run();
    logic [DW-1:0] neg_exp, e;
`ifdef POOL_RELU_EN
    neg_exp = 20'h00000;
`else
    neg_exp = 20'hFFFF0;
`endif
    for (int i = 0; i < 4096; i++) begin
      l0k0[i] = 20'($urandom);
      l0k1[i] = 20'($urandom);
    end
    l0k0[0]    = 20'h00010; l0k0[1]    = 20'h00020; l0k0[64]   = 20'h00030; l0k0[65]   = 20'h00005;
    l0k0[2]    = 20'hFFFF0; l0k0[3]    = 20'hFFFF0; l0k0[66]   = 20'hFFFF0; l0k0[67]   = 20'hFFFF0;
    l0k1[4030] = 20'h80000; l0k1[4031] = 20'h7FFFF; l0k1[4094] = 20'h00001; l0k1[4095] = 20'hFFFFF;

    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if ({busy, bus.crd, bus.caddr_rd, bus.csel} !== {1'b1, 1'b1, 12'd0, 3'b001}) begin
      failures++;
      $display("FAIL start_state got busy=%b crd=%b addr=%0d csel=%b exp 1 1 0 001",
               busy, bus.crd, bus.caddr_rd, bus.csel);
    end
    for (int i = 0; i < 20000 && busy; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL run_timeout busy=%b exp=0", busy);
    end
    repeat (3) tick();

    checks++;
    if (busy_cyc != 14336) begin
      failures++;
      $display("FAIL busy_len got=%0d exp=14336", busy_cyc);
    end
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL rd_wr_overlap got=%0d exp=0", overlap);
    end
    checks++;
    if (rd_idx != 8192 || wr_cnt != 4096) begin
      failures++;
      $display("FAIL access_count got rd=%0d wr=%0d exp rd=8192 wr=4096", rd_idx, wr_cnt);
    end
    checks++;
    if ({rd_log[0], rd_log[1], rd_log[2], rd_log[3]} !== {12'd0, 12'd1, 12'd64, 12'd65}) begin
      failures++;
      $display("FAIL pix0_addrs got=%0d,%0d,%0d,%0d exp=0,1,64,65",
               rd_log[0], rd_log[1], rd_log[2], rd_log[3]);
    end
    checks++;
    if ({rd_log[4092], rd_log[4093], rd_log[4094], rd_log[4095]} !==
        {12'd4030, 12'd4031, 12'd4094, 12'd4095}) begin
      failures++;
      $display("FAIL pix1023_addrs got=%0d,%0d,%0d,%0d exp=4030,4031,4094,4095",
               rd_log[4092], rd_log[4093], rd_log[4094], rd_log[4095]);
    end
    checks++;
    if ({rd_sel_log[0], rd_sel_log[4095], rd_sel_log[4096]} !== {3'b001, 3'b001, 3'b010}) begin
      failures++;
      $display("FAIL read_csel got=%b,%b,%b exp=001,001,010",
               rd_sel_log[0], rd_sel_log[4095], rd_sel_log[4096]);
    end
    checks++;
    if (l1m0[0] !== 20'h00030 || l2m[0] !== 20'h00030) begin
      failures++;
      $display("FAIL pix0_max got l1=%h l2=%h exp=00030", l1m0[0], l2m[0]);
    end
    checks++;
    if (l1m1[1023] !== 20'h7FFFF || l2m[2047] !== 20'h7FFFF) begin
      failures++;
      $display("FAIL signed_max got l1=%h l2=%h exp=7ffff", l1m1[1023], l2m[2047]);
    end
    checks++;
    if (l1m0[1] !== neg_exp || l2m[2] !== neg_exp) begin
      failures++;
      $display("FAIL negative_max got l1=%h l2=%h exp=%h", l1m0[1], l2m[2], neg_exp);
    end
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 1024; p++) begin
        e = ref_pool(k, p);
        checks++;
        if (((k == 0) ? l1m0[p] : l1m1[p]) !== e || l2m[2 * p + k] !== e) begin
          failures++;
          $display("FAIL model k=%0d p=%0d got l1=%h l2=%h exp=%h",
                   k, p, (k == 0) ? l1m0[p] : l1m1[p], l2m[2 * p + k], e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int wr_before;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    for (int i = 0; i < 10000 && rd_idx < 1201; i++) tick();
    checks++;
    if (rd_idx != 1201 || bus.crd !== 1'b1) begin
      failures++;
      $display("FAIL mid_reach got rd_idx=%0d crd=%b exp 1201 1", rd_idx, bus.crd);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, bus.cwr, bus.crd, bus.csel} !== 6'b000000) begin
      failures++;
      $display("FAIL mid_reset got busy=%b cwr=%b crd=%b csel=%b exp 0 0 0 000",
               busy, bus.cwr, bus.crd, bus.csel);
    end
    wr_before = wr_cnt;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (wr_cnt != wr_before) begin
      failures++;
      $display("FAIL mid_no_write got=%0d exp=%0d", wr_cnt, wr_before);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if ({busy, bus.crd, bus.caddr_rd, bus.csel} !== {1'b1, 1'b1, 12'd0, 3'b001}) begin
      failures++;
      $display("FAIL mid_restart got busy=%b crd=%b addr=%0d csel=%b exp 1 1 0 001",
               busy, bus.crd, bus.caddr_rd, bus.csel);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ready_held();
    int high, gap;
    high = 0;
    gap  = 0;
    ready = 1'b1;
    for (int i = 0; i < 5 && !busy; i++) tick();
    for (int i = 0; i < 20000 && busy; i++) begin
      high++;
      tick();
    end
    for (int i = 0; i < 10 && !busy; i++) begin
      gap++;
      tick();
    end
    ready = 1'b0;
    checks++;
    if (high != 14336) begin
      failures++;
      $display("FAIL held_busy_len got=%0d exp=14336", high);
    end
    checks++;
    if (gap != 2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL held_restart_gap got=%0d busy=%b exp=2 1", gap, busy);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_reset_mid();
    test_ready_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
